// File: rtl/mst_tlp_tx.sv
// mst_tlp_tx: drains the master FIFO filled by the Ethernet receive stage and
// turns each packet (command word, address high, address low, 2*PAYLOAD_DW
// data words) into a 3DW posted Memory Write TLP. The TLP is streamed 16 bits
// per cycle to the ECP3 PCIe core VC0 transmit interface.
//
// Ports:
//   sys_clk, sys_rst        clock, synchronous active-high reset
//   mst_dout/empty/rd_en    non-FWFT FIFO read side ([17]=start, [16]=end)
//   requester_id            bus/dev/func placed in header word H2
//   tx_ca_ph, tx_ca_pd      posted header / data (4DW units) credits
//   tx_rdy, tx_req          transmit grant / request
//   tx_data, tx_st, tx_end  TLP word stream with first/last markers
//   tlp_count, drop_count   wrapping counts of sent TLPs / aborted packets
//
// The whole packet is staged before requesting the core, so a FIFO that runs
// dry mid-packet never stalls the outgoing TLP.
module mst_tlp_tx #(
  parameter int unsigned PAYLOAD_DW = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [17:0] mst_dout,
  input  logic        mst_empty,
  output logic        mst_rd_en,
  input  logic [15:0] requester_id,
  input  logic [7:0]  tx_ca_ph,
  input  logic [12:0] tx_ca_pd,
  input  logic        tx_rdy,
  output logic        tx_req,
  output logic [15:0] tx_data,
  output logic        tx_st,
  output logic        tx_end,
  output logic [15:0] tlp_count,
  output logic [15:0] drop_count
);

  localparam int unsigned NWORDS  = 2 + 2 * PAYLOAD_DW;   // stored words
  localparam int unsigned NTX     = 4 + NWORDS;           // TLP words
  localparam int unsigned IW      = $clog2(NWORDS);
  localparam int unsigned TW      = $clog2(NTX + 1);
  localparam int unsigned PD_NEED = (PAYLOAD_DW + 3) / 4;

  typedef enum logic [2:0] {IDLE, FILL, WAIT_CREDIT, REQ, SEND} state_e;

  state_e        state_q;
  logic [IW-1:0] idx_q;
  logic [TW-1:0] wcnt_q;
  logic          rd_pend_q;
  logic [7:0]    tag_q;
  logic [15:0]   buf_q [NWORDS];
  logic [15:0]   tx_data_q;
  logic          tx_req_q, tx_st_q, tx_end_q;
  logic [15:0]   tlp_count_q, drop_count_q;

  logic          word_start, word_end, is_last, buf_we;
  logic [IW-1:0] buf_rd_idx;
  logic [15:0]   word_d;

  always_comb begin
    word_start = mst_dout[17];
    word_end   = mst_dout[16];
    is_last    = (idx_q == IW'(NWORDS - 1));
    buf_we     = rd_pend_q && (state_q == FILL) && !word_start;
    // Stored words plus the read in flight must never exceed the packet
    // size, so nothing is ever outstanding once FILL completes.
    mst_rd_en  = !sys_rst && !mst_empty &&
                 ((state_q == IDLE) ||
                  ((state_q == FILL) &&
                   ((32'(idx_q) + 32'(rd_pend_q)) < NWORDS)));
  end

  always_comb begin
    buf_rd_idx = IW'(wcnt_q - TW'(4));
    if (wcnt_q == TW'(0))      word_d = 16'h4000;
    else if (wcnt_q == TW'(1)) word_d = 16'(PAYLOAD_DW);
    else if (wcnt_q == TW'(2)) word_d = requester_id;
    else if (wcnt_q == TW'(3)) word_d = {tag_q, 8'hFF};
    else                       word_d = buf_q[buf_rd_idx];
  end

  // Staging buffer carries no reset; contents are only read after a full fill.
  always_ff @(posedge sys_clk) begin
    if (buf_we)
      buf_q[idx_q] <= (idx_q == IW'(1)) ? {mst_dout[15:2], 2'b00} : mst_dout[15:0];
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      wcnt_q       <= '0;
      rd_pend_q    <= 1'b0;
      tag_q        <= '0;
      tx_data_q    <= '0;
      tx_req_q     <= 1'b0;
      tx_st_q      <= 1'b0;
      tx_end_q     <= 1'b0;
      tlp_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      rd_pend_q <= mst_rd_en;
      case (state_q)
        IDLE: begin
          if (rd_pend_q && word_start) begin
            state_q <= FILL;
            idx_q   <= '0;
          end
        end
        FILL: begin
          if (rd_pend_q) begin
            if (word_start) begin
              // A start word mid-fill both aborts and begins the next packet.
              drop_count_q <= drop_count_q + 16'd1;
              idx_q        <= '0;
            end else if (is_last) begin
              if (word_end) begin
                state_q <= WAIT_CREDIT;
              end else begin
                drop_count_q <= drop_count_q + 16'd1;
                state_q      <= IDLE;
              end
            end else if (word_end) begin
              drop_count_q <= drop_count_q + 16'd1;
              state_q      <= IDLE;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end
        end
        WAIT_CREDIT: begin
          if ((tx_ca_ph != '0) && (tx_ca_pd >= 13'(PD_NEED))) begin
            state_q  <= REQ;
            tx_req_q <= 1'b1;
          end
        end
        REQ: begin
          if (tx_rdy) begin
            tx_req_q  <= 1'b0;
            tx_data_q <= word_d;
            tx_st_q   <= 1'b1;
            wcnt_q    <= TW'(1);
            state_q   <= SEND;
          end
        end
        SEND: begin
          if (wcnt_q == TW'(NTX)) begin
            tx_data_q   <= '0;
            tx_end_q    <= 1'b0;
            wcnt_q      <= '0;
            tlp_count_q <= tlp_count_q + 16'd1;
            tag_q       <= tag_q + 8'd1;
            state_q     <= IDLE;
          end else begin
            tx_data_q <= word_d;
            tx_st_q   <= 1'b0;
            tx_end_q  <= (wcnt_q == TW'(NTX - 1));
            wcnt_q    <= wcnt_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_req     = tx_req_q;
  assign tx_data    = tx_data_q;
  assign tx_st      = tx_st_q;
  assign tx_end     = tx_end_q;
  assign tlp_count  = tlp_count_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_mst_tlp_tx.sv
// Testbench for mst_tlp_tx: a non-FWFT FIFO model feeds packets, a scoreboard
// holds the expected TLP words pushed when each packet is queued, and every
// clock the sampled tx stream is popped against it.
module tb_mst_tlp_tx;
  localparam int unsigned P   = 8;
  localparam int unsigned NTX = 6 + 2 * P;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [17:0] mst_dout;
  logic        mst_empty;
  logic        mst_rd_en;
  logic [15:0] requester_id;
  logic [7:0]  tx_ca_ph;
  logic [12:0] tx_ca_pd;
  logic        tx_rdy;
  logic        tx_req;
  logic [15:0] tx_data;
  logic        tx_st, tx_end;
  logic [15:0] tlp_count, drop_count;

  always #5 sys_clk = ~sys_clk;

  mst_tlp_tx #(.PAYLOAD_DW(P)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .mst_dout(mst_dout), .mst_empty(mst_empty), .mst_rd_en(mst_rd_en),
    .requester_id(requester_id), .tx_ca_ph(tx_ca_ph), .tx_ca_pd(tx_ca_pd),
    .tx_rdy(tx_rdy), .tx_req(tx_req), .tx_data(tx_data),
    .tx_st(tx_st), .tx_end(tx_end),
    .tlp_count(tlp_count), .drop_count(drop_count)
  );

  typedef struct packed {
    logic [15:0] data;
    logic        st;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  logic [17:0] fifo_q[$];
  logic [17:0] pend_q[$];
  int          errors = 0;
  int          checks = 0;
  bit          in_pkt = 0;
  bit          mon_en = 0;
  int          req_age = 0;
  logic [7:0]  exp_tag;
  logic [15:0] exp_tlp, exp_drop;
  logic        s_req, s_rd, s_st, s_end;
  logic [15:0] s_data;

  // One clock: sample and score at negedge, then advance FIFO and tx_rdy.
  task automatic step();
    exp_t e;
    @(negedge sys_clk);
    s_req = tx_req; s_rd = mst_rd_en; s_st = tx_st; s_end = tx_end; s_data = tx_data;
    if (s_rd) begin
      checks++;
      if (mst_empty !== 1'b0) begin
        errors++;
        $display("FAIL read_when_empty: mst_rd_en=1 with mst_empty=%b", mst_empty);
      end
    end
    if (mon_en) begin
      if (in_pkt || tx_st === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got data=%h st=%b end=%b, none expected", tx_data, tx_st, tx_end);
          in_pkt = 0;
        end else begin
          e = exp_q.pop_front();
          if ({tx_data, tx_st, tx_end} !== {e.data, e.st, e.last}) begin
            errors++;
            $display("FAIL tlp_word: got data=%h st=%b end=%b, want data=%h st=%b end=%b",
                     tx_data, tx_st, tx_end, e.data, e.st, e.last);
          end
          in_pkt = !e.last;
        end
      end else begin
        checks++;
        if (tx_data !== 16'h0 || tx_end !== 1'b0) begin
          errors++;
          $display("FAIL idle_outputs: got data=%h end=%b, want 0000 0", tx_data, tx_end);
        end
      end
    end
    if (tx_req === 1'b1) req_age++; else req_age = 0;
    @(posedge sys_clk);
    #1;
    if (s_rd && fifo_q.size() != 0) mst_dout = fifo_q.pop_front();
    mst_empty = (fifo_q.size() == 0);
    tx_rdy    = (req_age >= 2);
  endtask

  task automatic do_reset();
    mon_en  = 0;
    sys_rst = 1'b1;
    fifo_q.delete(); pend_q.delete(); exp_q.delete();
    mst_empty = 1'b1;
    in_pkt = 0;
    step(); step();
    sys_rst = 1'b0;
    exp_tag = '0; exp_tlp = '0; exp_drop = '0;
    mon_en = 1;
  endtask

  // Builds FIFO words for a good packet and pushes its expected TLP.
  task automatic make_pkt(input logic [15:0] ahi, input logic [15:0] alo, input logic [15:0] base);
    exp_t e;
    pend_q.push_back({2'b10, 16'h90FF});
    pend_q.push_back({2'b00, ahi});
    pend_q.push_back({2'b00, alo});
    for (int unsigned i = 0; i < 2 * P; i++)
      pend_q.push_back({1'b0, (i == 2 * P - 1), base + 16'(i)});
    e = '{data: 16'h4000, st: 1'b1, last: 1'b0}; exp_q.push_back(e);
    e = '{data: 16'(P), st: 1'b0, last: 1'b0};  exp_q.push_back(e);
    e.data = requester_id;                       exp_q.push_back(e);
    e.data = {exp_tag, 8'hFF};                   exp_q.push_back(e);
    e.data = ahi;                                exp_q.push_back(e);
    e.data = {alo[15:2], 2'b00};                 exp_q.push_back(e);
    for (int unsigned i = 0; i < 2 * P; i++) begin
      e = '{data: base + 16'(i), st: 1'b0, last: (i == 2 * P - 1)};
      exp_q.push_back(e);
    end
    exp_tag = exp_tag + 8'd1;
    exp_tlp = exp_tlp + 16'd1;
  endtask

  task automatic move(input int n);
    for (int i = 0; (n < 0 || i < n) && pend_q.size() != 0; i++)
      fifo_q.push_back(pend_q.pop_front());
    mst_empty = (fifo_q.size() == 0);
  endtask

  task automatic wait_done(input string name, input int max);
    int n = 0;
    while ((exp_q.size() != 0 || in_pkt || fifo_q.size() != 0) && n < max) begin
      step(); n++;
    end
    checks++;
    if (n >= max) begin
      errors++;
      $display("FAIL %s_timeout: %0d words still expected after %0d cycles, want 0", name, exp_q.size(), max);
    end
    step(); step();
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    fifo_q.push_back({2'b10, 16'h0000});
    mst_empty = 1'b0;
    step(); step();
    checks++;
    if ({s_rd, tx_req, tx_st, tx_end, tx_data, tlp_count, drop_count} !== '0) begin
      errors++;
      $display("FAIL reset_state: got rd=%b req=%b st=%b end=%b data=%h tlp=%h drop=%h, want all 0",
               s_rd, tx_req, tx_st, tx_end, tx_data, tlp_count, drop_count);
    end
    do_reset();
  endtask

  task automatic test_normal();
    do_reset();
    tx_ca_ph = 8'd1; tx_ca_pd = 13'd2;
    make_pkt(16'h1234, 16'h5678, 16'h0000);
    move(-1);
    wait_done("normal", 300);
    checks++;
    if ({tlp_count, drop_count} !== {exp_tlp, exp_drop}) begin
      errors++;
      $display("FAIL normal_counts: got tlp=%h drop=%h, want tlp=%h drop=%h", tlp_count, drop_count, exp_tlp, exp_drop);
    end
  endtask

  task automatic test_dry_fifo();
    bit saw = 0;
    int n = 0;
    do_reset();
    make_pkt(16'h1234, 16'h5678, 16'h0000);
    move(3 + 8);
    while (fifo_q.size() != 0 && n < 50) begin step(); n++; end
    repeat (10) begin step(); saw |= s_req; end
    checks++;
    if (saw !== 1'b0) begin
      errors++;
      $display("FAIL dry_no_req: got tx_req=1 while packet incomplete, want 0");
    end
    move(-1);
    wait_done("dry", 300);
    checks++;
    if ({tlp_count, drop_count} !== {exp_tlp, exp_drop}) begin
      errors++;
      $display("FAIL dry_counts: got tlp=%h drop=%h, want tlp=%h drop=%h", tlp_count, drop_count, exp_tlp, exp_drop);
    end
  endtask

  task automatic test_early_end();
    bit saw = 0;
    do_reset();
    fifo_q.push_back({2'b10, 16'h90FF});
    fifo_q.push_back({2'b00, 16'hAAAA});
    fifo_q.push_back({2'b00, 16'hBBBB});
    for (int i = 0; i < 6; i++) fifo_q.push_back({1'b0, (i == 5), 16'(i)});
    mst_empty = 1'b0;
    exp_drop = 16'd1;
    repeat (30) begin step(); saw |= s_req; end
    checks++;
    if ({saw, tlp_count, drop_count} !== {1'b0, exp_tlp, exp_drop}) begin
      errors++;
      $display("FAIL early_end_drop: got req=%b tlp=%h drop=%h, want req=0 tlp=%h drop=%h",
               saw, tlp_count, drop_count, exp_tlp, exp_drop);
    end
    make_pkt(16'hCAFE, 16'hABCF, 16'h0100);
    move(-1);
    wait_done("early_end", 300);
    checks++;
    if ({tlp_count, drop_count} !== {exp_tlp, exp_drop}) begin
      errors++;
      $display("FAIL early_end_counts: got tlp=%h drop=%h, want tlp=%h drop=%h", tlp_count, drop_count, exp_tlp, exp_drop);
    end
  endtask

  task automatic test_restart();
    do_reset();
    fifo_q.push_back({2'b10, 16'h90FF});
    fifo_q.push_back({2'b00, 16'h1111});
    fifo_q.push_back({2'b00, 16'h2222});
    for (int i = 0; i < 3; i++) fifo_q.push_back({2'b00, 16'h0F00 + 16'(i)});
    exp_drop = 16'd1;
    make_pkt(16'h8000, 16'h0013, 16'h0200);
    move(-1);
    wait_done("restart", 300);
    checks++;
    if ({tlp_count, drop_count} !== {exp_tlp, exp_drop}) begin
      errors++;
      $display("FAIL restart_counts: got tlp=%h drop=%h, want tlp=%h drop=%h", tlp_count, drop_count, exp_tlp, exp_drop);
    end
  endtask

  task automatic test_credits();
    bit bad = 0;
    do_reset();
    tx_ca_ph = 8'd1; tx_ca_pd = 13'd1;
    make_pkt(16'h4444, 16'h5555, 16'h0300);
    move(-1);
    repeat (30) step();
    make_pkt(16'h6666, 16'h7777, 16'h0400);
    move(-1);
    repeat (50) begin step(); bad |= s_req | s_rd; end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL credit_hold: got tx_req or mst_rd_en high with pd=1, want both 0");
    end
    tx_ca_pd = 13'd2;
    step();
    checks++;
    if (s_req !== 1'b0) begin
      errors++;
      $display("FAIL credit_req_early: got tx_req=%b in cycle pd rises, want 0", s_req);
    end
    step();
    checks++;
    if (s_req !== 1'b1) begin
      errors++;
      $display("FAIL credit_req_rise: got tx_req=%b cycle after pd=2, want 1", s_req);
    end
    wait_done("credits", 400);
    checks++;
    if ({tlp_count, drop_count} !== {exp_tlp, exp_drop}) begin
      errors++;
      $display("FAIL credit_counts: got tlp=%h drop=%h, want tlp=%h drop=%h", tlp_count, drop_count, exp_tlp, exp_drop);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    make_pkt(16'h0001, 16'h0002, 16'h1000);
    make_pkt(16'h0003, 16'h0006, 16'h2000);
    make_pkt(16'h0005, 16'hFFFF, 16'h3000);
    move(-1);
    wait_done("back_to_back", 600);
    checks++;
    if ({tlp_count, drop_count} !== {exp_tlp, exp_drop}) begin
      errors++;
      $display("FAIL b2b_counts: got tlp=%h drop=%h, want tlp=%h drop=%h", tlp_count, drop_count, exp_tlp, exp_drop);
    end
  endtask

  task automatic test_reset_mid_send();
    bit saw_end = 0;
    int seen = 0;
    int n = 0;
    do_reset();
    make_pkt(16'h1234, 16'h5678, 16'h0000);
    move(-1);
    wait_done("pre_reset", 300);
    mon_en = 0;
    make_pkt(16'h9999, 16'h8888, 16'h0500);
    exp_q.delete();
    move(-1);
    while (s_st !== 1'b1 && n < 200) begin step(); n++; end
    checks++;
    if (s_st !== 1'b1) begin
      errors++;
      $display("FAIL mid_send_start: got no tx_st within 200 cycles, want tx_st=1");
    end
    seen = 1;
    while (seen < 11) begin step(); seen++; saw_end |= s_end; end
    sys_rst = 1'b1;
    step();
    saw_end |= s_end;
    sys_rst = 1'b0;
    exp_tag = '0; exp_tlp = '0; exp_drop = '0;
    in_pkt = 0;
    step();
    checks++;
    if ({saw_end, s_st, s_end, s_req, s_data, tlp_count, drop_count} !== '0) begin
      errors++;
      $display("FAIL reset_mid_send: got saw_end=%b st=%b end=%b req=%b data=%h tlp=%h drop=%h, want all 0",
               saw_end, s_st, s_end, s_req, s_data, tlp_count, drop_count);
    end
    mon_en = 1;
    make_pkt(16'h7000, 16'h0101, 16'h0600);
    move(-1);
    wait_done("post_reset", 300);
    checks++;
    if ({tlp_count, drop_count} !== {exp_tlp, exp_drop}) begin
      errors++;
      $display("FAIL post_reset_counts: got tlp=%h drop=%h, want tlp=%h drop=%h", tlp_count, drop_count, exp_tlp, exp_drop);
    end
  endtask

  initial begin
    sys_rst = 1'b1; mst_dout = '0; mst_empty = 1'b1;
    requester_id = 16'hBEEF; tx_ca_ph = 8'd1; tx_ca_pd = 13'd2; tx_rdy = 1'b0;
    exp_tag = '0; exp_tlp = '0; exp_drop = '0;
    test_reset();
    test_normal();
    test_dry_fifo();
    test_early_end();
    test_restart();
    test_credits();
    test_back_to_back();
    test_reset_mid_send();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
